mc_ctrl_fsm: RTL and testbench
==============================

Name: mc_ctrl_fsm

Overview:
Multi-cycle MIPS main control unit. It drives the 3-bit ALU operation code and all datapath selects and strobes, and consumes the ALU's zero flag. It sequences fetch, decode, execute, memory and writeback one state per cycle, and stalls on a memory ready handshake. The block sits between the instruction register and the ALU/regfile/memory datapath.

Parameters:
MEM_WAIT_EN, 1, 1: honour mem_ready. 0: treat memory as always ready.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26], stable after FETCH
funct  in  6  IR[5:0]
zero_flag  in  1  ALU zero flag (result == 0)
mem_ready  in  1  memory completes the current read/write this cycle
alu_ctrl  out  3  and 000, or 001, add 010, sub 110, slt 111, sll 011, srl 100
alu_src_a  out  1  0 = PC, 1 = reg A
alu_src_b  out  2  00 = reg B, 01 = 4, 10 = imm, 11 = sign-ext imm<<2
ext_zero  out  1  imm zero-extended (andi/ori), else sign-extended
pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
pc_en  out  1  PC write enable
i_or_d  out  1  0 = PC address, 1 = ALUOut address
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_write  out  1  IR load
reg_write  out  1  regfile write
reg_dst  out  1  1 = rd, 0 = rt
mem_to_reg  out  1  1 = MDR, 0 = ALUOut
inst_done  out  1  one-cycle pulse on instruction retire
illegal_op  out  1  one-cycle pulse on unsupported opcode/funct
state  out  4  current state, for debug

Behaviour:
- State register resets asynchronously to FETCH. While rst_n=0, all strobes (pc_en, ir_write, reg_write, mem_read, mem_write, inst_done, illegal_op) are 0 and all selects are 0.
- Outputs are decoded from state. pc_en additionally depends on mem_ready and zero_flag. Any output not listed for a state is 0.
- Supported R-type (opcode 0) functs: add 20h, sub 22h, and 24h, or 25h, slt 2Ah, sll 00h, srl 02h.
- Supported opcodes: lw 23h, sw 2Bh, beq 04h, bne 05h, j 02h, addi 08h, slti 0Ah, andi 0Ch, ori 0Dh.
- FETCH(0): mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_ctrl=010. If ready: ir_write=1, pc_en=1, next DECODE. Else hold with no ir_write/pc_en.
- DECODE(1): alu_src_b=11, alu_ctrl=010 (branch target into ALUOut). Next state by opcode: lw/sw to MEM_ADDR, R to R_EXEC, beq/bne to BRANCH, j to JUMP, I-ops to I_EXEC. Unsupported opcode or funct: illegal_op=1, next FETCH, no writes.
- MEM_ADDR(2): alu_src_a=1, alu_src_b=10, add. Next MEM_RD (lw) or MEM_WR (sw).
- MEM_RD(3): mem_read=1, i_or_d=1. Hold until ready, then MEM_WB.
- MEM_WB(4): reg_write=1, mem_to_reg=1, reg_dst=0, inst_done=1. Next FETCH.
- MEM_WR(5): mem_write=1, i_or_d=1. Hold until ready. On ready: inst_done=1, next FETCH. mem_write stays high through wait cycles.
- R_EXEC(6): alu_src_a=1, alu_src_b=00, alu_ctrl per funct. Next R_WB.
- R_WB(7): reg_write=1, reg_dst=1, mem_to_reg=0, inst_done=1. Next FETCH.
- BRANCH(8): alu_src_a=1, alu_src_b=00, sub, pc_source=01. pc_en = zero_flag for beq, !zero_flag for bne. inst_done=1. Next FETCH.
- JUMP(9): pc_source=10, pc_en=1, inst_done=1. Next FETCH.
- I_EXEC(10): alu_src_a=1, alu_src_b=10. addi uses add, slti uses slt, andi uses and with ext_zero=1, ori uses or with ext_zero=1. Next I_WB.
- I_WB(11): reg_write=1, reg_dst=0, mem_to_reg=0, inst_done=1. Next FETCH. ext_zero and alu_ctrl are held as in I_EXEC.
- Encodings 12-15 are unreachable. If entered, go to FETCH with no strobes.
- Zero-wait latency in cycles, counting FETCH: lw 5, sw 4, R 4, I 4, beq/bne 3, j 3. Each low-ready cycle adds 1.
- With MEM_WAIT_EN=0, FETCH, MEM_RD and MEM_WR always take 1 cycle.
- Async reset mid-instruction: strobes drop immediately and the state returns to FETCH. A pending memory write is abandoned.

Test Plan:
- Reset held 3 cycles, then released, mem_ready=1 -> state=0 during reset with all strobes 0. First cycle after release: mem_read=1, alu_ctrl=010, ir_write=1, pc_en=1.
- R add (op 00h, funct 20h) -> states 0,1,6,7. alu_ctrl=010 in state 6. reg_write=1, reg_dst=1 and inst_done=1 in state 7 only.
- lw with mem_ready low 2 cycles in MEM_RD -> 7 total cycles. mem_read held through the stall. reg_write=1, mem_to_reg=1 in the last cycle.
- beq with zero_flag=1 -> pc_en=1, pc_source=01 in state 8. beq with zero_flag=0 -> pc_en=0. bne with zero_flag=0 -> pc_en=1.
- Opcode 3Fh -> illegal_op pulses in DECODE, next state 0, no reg_write/mem_write. R funct 27h gives the same response.
- sw, with rst_n asserted low during MEM_WR -> mem_write falls to 0 asynchronously, state=0. After release, fetch resumes.

Source files
------------

// File: rtl/mc_ctrl_fsm_if.sv
// Control bundle between the multi-cycle MIPS main control FSM and its datapath.
// The master side (the FSM) consumes instruction fields and flags and drives selects/strobes.
interface mc_ctrl_fsm_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero_flag;
    logic       mem_ready;

    logic [2:0] alu_ctrl;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic [1:0] pc_source;
    logic       pc_en;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       inst_done;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  opcode, funct, zero_flag, mem_ready,
        output alu_ctrl, alu_src_a, alu_src_b, ext_zero, pc_source, pc_en,
               i_or_d, mem_read, mem_write, ir_write, reg_write, reg_dst,
               mem_to_reg, inst_done, illegal_op, state
    );

    modport slave (
        output opcode, funct, zero_flag, mem_ready,
        input  alu_ctrl, alu_src_a, alu_src_b, ext_zero, pc_source, pc_en,
               i_or_d, mem_read, mem_write, ir_write, reg_write, reg_dst,
               mem_to_reg, inst_done, illegal_op, state
    );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS main control unit: one state per cycle from fetch to writeback,
// with stalls on the memory ready handshake. Outputs are decoded from the current state.
module mc_ctrl_fsm #(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input logic           clk,
    input logic           rst_n,
    mc_ctrl_fsm_if.master ctl_if
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEM_ADDR = 4'd2;
    localparam logic [3:0] S_MEM_RD   = 4'd3;
    localparam logic [3:0] S_MEM_WB   = 4'd4;
    localparam logic [3:0] S_MEM_WR   = 4'd5;
    localparam logic [3:0] S_R_EXEC   = 4'd6;
    localparam logic [3:0] S_R_WB     = 4'd7;
    localparam logic [3:0] S_BRANCH   = 4'd8;
    localparam logic [3:0] S_JUMP     = 4'd9;
    localparam logic [3:0] S_I_EXEC   = 4'd10;
    localparam logic [3:0] S_I_WB     = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SLL = 3'b011;
    localparam logic [2:0] ALU_SRL = 3'b100;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    logic [3:0] state_q, state_d;
    logic       mem_rdy;
    logic       r_legal, op_legal, i_zext;
    logic [2:0] r_alu, i_alu;

    logic [2:0] alu_ctrl;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic [1:0] pc_source;
    logic       pc_en, i_or_d, mem_read, mem_write, ir_write;
    logic       reg_write, reg_dst, mem_to_reg, inst_done, illegal_op;

    assign mem_rdy = MEM_WAIT_EN ? ctl_if.mem_ready : 1'b1;

    // Instruction field decode; the IR is stable from DECODE onwards.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        r_legal = 1'b1;
        r_alu   = ALU_ADD;
        case (ctl_if.funct)
            FN_ADD:  r_alu = ALU_ADD;
            FN_SUB:  r_alu = ALU_SUB;
            FN_AND:  r_alu = ALU_AND;
            FN_OR:   r_alu = ALU_OR;
            FN_SLT:  r_alu = ALU_SLT;
            FN_SLL:  r_alu = ALU_SLL;
            FN_SRL:  r_alu = ALU_SRL;
            default: r_legal = 1'b0;
        endcase

        i_alu  = ALU_ADD;
        i_zext = 1'b0;
        case (ctl_if.opcode)
            OP_SLTI: i_alu = ALU_SLT;
            OP_ANDI: begin i_alu = ALU_AND; i_zext = 1'b1; end
            OP_ORI:  begin i_alu = ALU_OR;  i_zext = 1'b1; end
            default: i_alu = ALU_ADD;
        endcase

        case (ctl_if.opcode)
            OP_RTYPE:                          op_legal = r_legal;
            OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J,
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: op_legal = 1'b1;
            default:                           op_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_rdy) state_d = S_DECODE;
            S_DECODE: begin
                if (!op_legal) begin
                    state_d = S_FETCH;
                end else begin
                    case (ctl_if.opcode)
                        OP_LW, OP_SW:   state_d = S_MEM_ADDR;
                        OP_RTYPE:       state_d = S_R_EXEC;
                        OP_BEQ, OP_BNE: state_d = S_BRANCH;
                        OP_J:           state_d = S_JUMP;
                        default:        state_d = S_I_EXEC;
                    endcase
                end
            end
            S_MEM_ADDR: state_d = (ctl_if.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_rdy) state_d = S_MEM_WB;
            S_MEM_WR:   if (mem_rdy) state_d = S_FETCH;
            S_R_EXEC:   state_d = S_R_WB;
            S_I_EXEC:   state_d = S_I_WB;
            default:    state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Output decode is also gated by rst_n so strobes fall the moment reset asserts.
    always_comb begin
        alu_ctrl   = 3'b000;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        ext_zero   = 1'b0;
        pc_source  = 2'b00;
        pc_en      = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        inst_done  = 1'b0;
        illegal_op = 1'b0;
        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    alu_ctrl  = ALU_ADD;
                    ir_write  = mem_rdy;
                    pc_en     = mem_rdy;
                end
                S_DECODE: begin
                    alu_src_b  = 2'b11;
                    alu_ctrl   = ALU_ADD;
                    illegal_op = !op_legal;
                end
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_ctrl  = ALU_ADD;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    inst_done  = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                    inst_done = mem_rdy;
                end
                S_R_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_ctrl  = r_alu;
                end
                S_R_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                    inst_done = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_ctrl  = ALU_SUB;
                    pc_source = 2'b01;
                    pc_en     = (ctl_if.opcode == OP_BEQ) ? ctl_if.zero_flag : !ctl_if.zero_flag;
                    inst_done = 1'b1;
                end
                S_JUMP: begin
                    pc_source = 2'b10;
                    pc_en     = 1'b1;
                    inst_done = 1'b1;
                end
                S_I_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_ctrl  = i_alu;
                    ext_zero  = i_zext;
                end
                S_I_WB: begin
                    reg_write = 1'b1;
                    inst_done = 1'b1;
                    alu_ctrl  = i_alu;
                    ext_zero  = i_zext;
                end
                default: ;
            endcase
        end
    end

    assign ctl_if.alu_ctrl   = alu_ctrl;
    assign ctl_if.alu_src_a  = alu_src_a;
    assign ctl_if.alu_src_b  = alu_src_b;
    assign ctl_if.ext_zero   = ext_zero;
    assign ctl_if.pc_source  = pc_source;
    assign ctl_if.pc_en      = pc_en;
    assign ctl_if.i_or_d     = i_or_d;
    assign ctl_if.mem_read   = mem_read;
    assign ctl_if.mem_write  = mem_write;
    assign ctl_if.ir_write   = ir_write;
    assign ctl_if.reg_write  = reg_write;
    assign ctl_if.reg_dst    = reg_dst;
    assign ctl_if.mem_to_reg = mem_to_reg;
    assign ctl_if.inst_done  = inst_done;
    assign ctl_if.illegal_op = illegal_op;
    assign ctl_if.state      = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: per-cycle expected control words are queued
// from an independent model when an instruction is issued and compared at each negedge.
module tb_mc_ctrl_fsm;

    typedef struct packed {
        logic [3:0] st;
        logic [2:0] alu;
        logic       src_a;
        logic [1:0] src_b;
        logic       ext_zero;
        logic [1:0] pc_src;
        logic       pc_en;
        logic       i_or_d;
        logic       mem_rd;
        logic       mem_wr;
        logic       ir_wr;
        logic       reg_wr;
        logic       reg_dst;
        logic       m2r;
        logic       done;
        logic       ill;
    } ctl_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail = 0;
    ctl_t sb[$];

    mc_ctrl_fsm_if ctl_if();

    mc_ctrl_fsm #(.MEM_WAIT_EN(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctl_if(ctl_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic ctl_t observe();
        ctl_t c;
        c = {ctl_if.state, ctl_if.alu_ctrl, ctl_if.alu_src_a, ctl_if.alu_src_b, ctl_if.ext_zero,
             ctl_if.pc_source, ctl_if.pc_en, ctl_if.i_or_d, ctl_if.mem_read, ctl_if.mem_write,
             ctl_if.ir_write, ctl_if.reg_write, ctl_if.reg_dst, ctl_if.mem_to_reg,
             ctl_if.inst_done, ctl_if.illegal_op};
        return c;
    endfunction

    function automatic logic legal(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00) return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02};
        return op inside {6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h08, 6'h0A, 6'h0C, 6'h0D};
    endfunction

    function automatic logic [2:0] r_code(input logic [5:0] fn);
        case (fn)
            6'h20: return 3'b010;
            6'h22: return 3'b110;
            6'h24: return 3'b000;
            6'h25: return 3'b001;
            6'h2A: return 3'b111;
            6'h00: return 3'b011;
            6'h02: return 3'b100;
            default: return 3'bxxx;
        endcase
    endfunction

    function automatic logic [2:0] i_code(input logic [5:0] op);
        case (op)
            6'h08: return 3'b010;
            6'h0A: return 3'b111;
            6'h0C: return 3'b000;
            6'h0D: return 3'b001;
            default: return 3'bxxx;
        endcase
    endfunction

    // Expected control word for a given state and inputs, straight from the state table.
    function automatic ctl_t model(input logic [3:0] st, input logic [5:0] op, input logic [5:0] fn,
                                   input logic rdy, input logic zf);
        ctl_t c;
        c = '0;
        c.st = st;
        case (st)
            4'd0:  begin c.mem_rd = 1; c.src_b = 2'b01; c.alu = 3'b010; c.ir_wr = rdy; c.pc_en = rdy; end
            4'd1:  begin c.src_b = 2'b11; c.alu = 3'b010; c.ill = !legal(op, fn); end
            4'd2:  begin c.src_a = 1; c.src_b = 2'b10; c.alu = 3'b010; end
            4'd3:  begin c.mem_rd = 1; c.i_or_d = 1; end
            4'd4:  begin c.reg_wr = 1; c.m2r = 1; c.done = 1; end
            4'd5:  begin c.mem_wr = 1; c.i_or_d = 1; c.done = rdy; end
            4'd6:  begin c.src_a = 1; c.alu = r_code(fn); end
            4'd7:  begin c.reg_wr = 1; c.reg_dst = 1; c.done = 1; end
            4'd8:  begin c.src_a = 1; c.alu = 3'b110; c.pc_src = 2'b01; c.done = 1;
                         c.pc_en = (op == 6'h04) ? zf : !zf; end
            4'd9:  begin c.pc_src = 2'b10; c.pc_en = 1; c.done = 1; end
            4'd10: begin c.src_a = 1; c.src_b = 2'b10; c.alu = i_code(op);
                         c.ext_zero = (op == 6'h0C || op == 6'h0D); end
            4'd11: begin c.reg_wr = 1; c.done = 1; c.alu = i_code(op);
                         c.ext_zero = (op == 6'h0C || op == 6'h0D); end
            default: ;
        endcase
        return c;
    endfunction

    // sts holds one state per nibble and rdy one mem_ready bit per cycle, cycle 0 in the LSBs.
    task automatic run(input string name, input logic [5:0] op, input logic [5:0] fn,
                       input logic zf, input int n, input logic [47:0] sts, input logic [11:0] rdy);
        ctl_t exp;
        for (int i = 0; i < n; i++) sb.push_back(model(sts[i*4 +: 4], op, fn, rdy[i], zf));
        ctl_if.opcode    = op;
        ctl_if.funct     = fn;
        ctl_if.zero_flag = zf;
        for (int i = 0; i < n; i++) begin
            ctl_if.mem_ready = rdy[i];
            @(negedge clk);
            exp = sb.pop_front();
            check($sformatf("%s_c%0d", name, i), 32'(observe()), 32'(exp));
            @(posedge clk);
            #1;
        end
    endtask

    logic [5:0] r_fns[6] = '{6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02};
    logic [5:0] i_ops[4] = '{6'h08, 6'h0A, 6'h0C, 6'h0D};

    initial begin
        ctl_t exp;
        rst_n            = 1'b0;
        ctl_if.opcode    = 6'h00;
        ctl_if.funct     = 6'h20;
        ctl_if.zero_flag = 1'b0;
        ctl_if.mem_ready = 1'b1;

        for (int i = 0; i < 3; i++) begin
            sb.push_back('0);
            @(negedge clk);
            exp = sb.pop_front();
            check($sformatf("reset_c%0d", i), 32'(observe()), 32'(exp));
        end
        @(posedge clk);
        #1 rst_n = 1'b1;

        run("r_add", 6'h00, 6'h20, 1'b0, 4, 48'h7610, 12'hF);
        foreach (r_fns[k]) run($sformatf("r_fn%h", r_fns[k]), 6'h00, r_fns[k], 1'b0, 4, 48'h7610, 12'hF);
        run("lw_stall", 6'h23, 6'h15, 1'b0, 7, 48'h4333210, 12'h067);
        run("lw", 6'h23, 6'h15, 1'b0, 5, 48'h43210, 12'h01F);
        run("sw", 6'h2B, 6'h15, 1'b0, 4, 48'h5210, 12'hF);
        run("sw_wait", 6'h2B, 6'h15, 1'b0, 5, 48'h55210, 12'h017);
        run("beq_z1", 6'h04, 6'h15, 1'b1, 3, 48'h810, 12'h7);
        run("beq_z0", 6'h04, 6'h15, 1'b0, 3, 48'h810, 12'h7);
        run("bne_z0", 6'h05, 6'h15, 1'b0, 3, 48'h810, 12'h7);
        run("bne_z1", 6'h05, 6'h15, 1'b1, 3, 48'h810, 12'h7);
        run("jump", 6'h02, 6'h15, 1'b0, 3, 48'h910, 12'h7);
        foreach (i_ops[k]) run($sformatf("iop%h", i_ops[k]), i_ops[k], 6'h15, 1'b0, 4, 48'hBA10, 12'hF);
        run("fetch_stall", 6'h00, 6'h20, 1'b0, 6, 48'h761000, 12'h03C);
        run("ill_op", 6'h3F, 6'h20, 1'b0, 2, 48'h10, 12'h3);
        run("ill_fn", 6'h00, 6'h27, 1'b0, 2, 48'h10, 12'h3);
        run("after_ill", 6'h02, 6'h15, 1'b0, 3, 48'h910, 12'h7);

        // sw stalled in MEM_WR, then reset asserted between clock edges.
        run("sw_rst", 6'h2B, 6'h15, 1'b0, 3, 48'h210, 12'h7);
        ctl_if.mem_ready = 1'b0;
        sb.push_back(model(4'd5, 6'h2B, 6'h15, 1'b0, 1'b0));
        @(negedge clk);
        exp = sb.pop_front();
        check("sw_rst_memwr", 32'(observe()), 32'(exp));
        #2 rst_n = 1'b0;
        sb.push_back('0);
        #1;
        exp = sb.pop_front();
        check("sw_rst_async", 32'(observe()), 32'(exp));
        @(posedge clk);
        sb.push_back('0);
        @(negedge clk);
        exp = sb.pop_front();
        check("sw_rst_held", 32'(observe()), 32'(exp));
        @(posedge clk);
        #1 rst_n = 1'b1;
        run("post_rst", 6'h02, 6'h15, 1'b0, 3, 48'h910, 12'h7);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
